// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU widths and the buffered result entry record.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int SEL_WIDTH = 4;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic                 carry;
        logic                 zero;
        logic [SEL_WIDTH-1:0] select;
    } alu_entry_t;

    // The zero flag is captured with the entry so the read side needs no compare.
    function automatic alu_entry_t make_entry(
        input logic [ALU_WIDTH-1:0] result,
        input logic                 carry,
        input logic [SEL_WIDTH-1:0] select
    );
        alu_entry_t e;
        e.result = result;
        e.carry  = carry;
        e.zero   = (result == '0);
        e.select = select;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_result_mem.sv
// ============================================================================
// Module   : alu_result_mem
// Brief    : DEPTH x entry storage, one synchronous write port, one async read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  alu_entry_t               i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output alu_entry_t               o_rdata
);

    // Contents are deliberately not reset; the controller masks reads while empty.
    alu_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/alu_result_buffer.sv
// ============================================================================
// Module   : alu_result_buffer
// Brief    : First-word fall-through buffer for ALU results with carry stats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_carry,
    input  logic [3:0]               in_select,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic [3:0]               out_select,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               carry_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    if (WIDTH != ALU_WIDTH) begin : g_width_check
        $error("alu_result_buffer: WIDTH must equal alu_pkg::ALU_WIDTH");
    end

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [7:0]         r_carry_count;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    alu_entry_t w_wr_entry;
    alu_entry_t w_rd_entry;

    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);
    // A full buffer refuses pushes even when the head is leaving this cycle.
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    assign w_wr_entry = make_entry(in_result, in_carry, in_select);

    alu_result_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_carry_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && in_carry && (r_carry_count != 8'hFF)) begin
                r_carry_count <= r_carry_count + 8'd1;
            end
        end
    end

    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    assign out_result  = w_empty ? '0   : w_rd_entry.result;
    assign out_carry   = w_empty ? 1'b0 : w_rd_entry.carry;
    assign out_zero    = w_empty ? 1'b0 : w_rd_entry.zero;
    assign out_select  = w_empty ? '0   : w_rd_entry.select;
    assign count       = r_count;
    assign carry_count = r_carry_count;

endmodule

`default_nettype wire
